// File: rtl/pb_loader_pkg.sv
// Shared types and constants for the PicoBlaze program loader.
package pb_loader_pkg;

    localparam int unsigned PROG_DEPTH = 1024;
    localparam int unsigned PROG_AW    = 10;
    localparam int unsigned INSTR_W    = 18;

    // Loader frame states.
    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StData,
        StCsum,
        StDone,
        StErr
    } ld_state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    // Word count is legal when it covers 1..PROG_DEPTH words.
    function automatic logic cnt_legal(input logic [15:0] cnt);
        return (cnt != 16'd0) && (cnt <= 16'(PROG_DEPTH));
    endfunction

endpackage

// File: rtl/pb_loader_wordpack.sv
// Assembles three MSB-first bytes into one 18-bit instruction word.
// The third byte is used directly so the word is ready in its handshake cycle.
module pb_loader_wordpack
    import pb_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               byte_valid_i,
    input  logic [7:0]         byte_i,
    output logic [INSTR_W-1:0] word_o,
    output logic               word_rdy_o
);

    logic [1:0] idx_q, idx_d;
    logic [1:0] hi_q, hi_d;
    logic [7:0] mid_q, mid_d;

    // Byte index and partial-word registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 2'd0;
            hi_q  <= 2'd0;
            mid_q <= 8'd0;
        end else begin
            idx_q <= idx_d;
            hi_q  <= hi_d;
            mid_q <= mid_d;
        end
    end

    // Capture B0[1:0] and B1, advance the index modulo 3.
    always_comb begin
        idx_d = idx_q;
        hi_d  = hi_q;
        mid_d = mid_q;
        if (clr_i) begin
            idx_d = 2'd0;
        end else if (byte_valid_i) begin
            unique case (idx_q)
                2'd0: begin
                    hi_d  = byte_i[1:0];
                    idx_d = 2'd1;
                end
                2'd1: begin
                    mid_d = byte_i;
                    idx_d = 2'd2;
                end
                default: idx_d = 2'd0;
            endcase
        end
    end

    // Word output and completion pulse.
    always_comb begin
        word_o     = {hi_q, mid_q, byte_i};
        word_rdy_o = byte_valid_i && !clr_i && (idx_q == 2'd2);
    end

endmodule

// File: rtl/pb_prog_loader.sv
// Streams a checksummed program image from a byte source into the PicoBlaze
// program RAM write port, holding the CPU in reset until a frame verifies.
module pb_prog_loader
    import pb_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter bit          BOOT_HOLD   = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         rx_data_i,
    input  logic               rx_valid_i,
    output logic               rx_ready_o,
    output logic               ram_we_o,
    output logic [PROG_AW-1:0] ram_addr_o,
    output logic [INSTR_W-1:0] ram_data_o,
    output logic               cpu_rst_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [1:0]         err_code_o
);

    // Gap counter only has to reach TIMEOUT_CYC-1; the next idle cycle fires.
    localparam int unsigned GapW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [GapW-1:0] GapMax = GapW'(TIMEOUT_CYC - 1);

    ld_state_e state_q, state_d;

    logic [1:0]         hdr_idx_q, hdr_idx_d;
    logic [7:0]         cnt_h_q, cnt_h_d;
    logic [10:0]        wcnt_q, wcnt_d;
    logic [PROG_AW-1:0] addr_q, addr_d;
    logic [7:0]         sum_q, sum_d;
    logic [GapW-1:0]    gap_q, gap_d;

    logic               ram_we_q, ram_we_d;
    logic [PROG_AW-1:0] ram_addr_q, ram_addr_d;
    logic [INSTR_W-1:0] ram_data_q, ram_data_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic               done_q, done_d;
    logic [1:0]         err_code_q, err_code_d;

    logic               busy;
    logic               is_sync;
    logic               tmo;
    logic [7:0]         byte_sum;
    logic [15:0]        cnt_full;
    logic               pack_clr;
    logic               pack_valid;
    logic [INSTR_W-1:0] pack_word;
    logic               pack_rdy;

    // Decode helpers shared by the next-state logic.
    always_comb begin
        busy       = (state_q == StHdr) || (state_q == StData) || (state_q == StCsum);
        is_sync    = rx_valid_i && (rx_data_i == SYNC_BYTE);
        byte_sum   = sum_q + rx_data_i;
        cnt_full   = {cnt_h_q, rx_data_i};
        // An accepted byte always beats an expiring timeout.
        tmo        = busy && !rx_valid_i && (gap_q == GapMax);
        pack_clr   = (state_q != StData);
        pack_valid = rx_valid_i && (state_q == StData);
    end

    pb_loader_wordpack u_wordpack (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (pack_clr),
        .byte_valid_i (pack_valid),
        .byte_i       (rx_data_i),
        .word_o       (pack_word),
        .word_rdy_o   (pack_rdy)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            hdr_idx_q  <= 2'd0;
            cnt_h_q    <= 8'd0;
            wcnt_q     <= 11'd0;
            addr_q     <= '0;
            sum_q      <= 8'd0;
            gap_q      <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            cpu_rst_q  <= BOOT_HOLD;
            done_q     <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            hdr_idx_q  <= hdr_idx_d;
            cnt_h_q    <= cnt_h_d;
            wcnt_q     <= wcnt_d;
            addr_q     <= addr_d;
            sum_q      <= sum_d;
            gap_q      <= gap_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            err_code_q <= err_code_d;
        end
    end

    // Frame parser: next state, counters, checksum and output strobes.
    always_comb begin
        state_d    = state_q;
        hdr_idx_d  = hdr_idx_q;
        cnt_h_d    = cnt_h_q;
        wcnt_d     = wcnt_q;
        addr_d     = addr_q;
        sum_d      = sum_q;
        gap_d      = gap_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        cpu_rst_d  = cpu_rst_q;
        done_d     = 1'b0;
        err_code_d = err_code_q;

        if (busy) begin
            if (rx_valid_i) begin
                gap_d = '0;
            end else if (!tmo) begin
                gap_d = gap_q + GapW'(1);
            end
        end

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (is_sync) begin
                    state_d    = StHdr;
                    cpu_rst_d  = 1'b1;
                    err_code_d = ERR_NONE;
                    sum_d      = 8'd0;
                    hdr_idx_d  = 2'd0;
                    gap_d      = '0;
                end
            end

            StHdr: begin
                if (rx_valid_i) begin
                    sum_d     = byte_sum;
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    unique case (hdr_idx_q)
                        2'd0: addr_d[PROG_AW-1:8] = rx_data_i[1:0];
                        2'd1: addr_d[7:0] = rx_data_i;
                        2'd2: cnt_h_d = rx_data_i;
                        default: begin
                            if (cnt_legal(cnt_full)) begin
                                state_d = StData;
                                wcnt_d  = cnt_full[10:0];
                            end else begin
                                state_d    = StErr;
                                err_code_d = ERR_LEN;
                            end
                        end
                    endcase
                end
            end

            StData: begin
                if (rx_valid_i) begin
                    sum_d = byte_sum;
                end
                if (pack_rdy) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = addr_q;
                    ram_data_d = pack_word;
                    // Address wraps naturally at the RAM depth.
                    addr_d     = addr_q + PROG_AW'(1);
                    wcnt_d     = wcnt_q - 11'd1;
                    if (wcnt_q == 11'd1) begin
                        state_d = StCsum;
                    end
                end
            end

            StCsum: begin
                if (rx_valid_i) begin
                    sum_d = byte_sum;
                    if (byte_sum == 8'd0) begin
                        state_d   = StDone;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d    = StErr;
                        err_code_d = ERR_CSUM;
                    end
                end
            end

            default: state_d = StIdle;
        endcase

        if (tmo) begin
            state_d    = StErr;
            err_code_d = ERR_TMO;
        end
    end

    // Output mapping; the loader never back-pressures the byte source.
    always_comb begin
        rx_ready_o = 1'b1;
        ram_we_o   = ram_we_q;
        ram_addr_o = ram_addr_q;
        ram_data_o = ram_data_q;
        cpu_rst_o  = cpu_rst_q;
        busy_o     = busy;
        done_o     = done_q;
        err_o      = (state_q == StErr);
        err_code_o = err_code_q;
    end

endmodule
